config_latch_bank: RTL and testbench
====================================

# config_latch_bank

Parametrised, double-buffered configuration memory bank: NUM_WL word lines × DATA_WIDTH bit lines of configuration latches. Writes land in a shadow array addressed by word line; a single `commit` transfers every shadow row into the active array that drives the fabric, so the fabric never sees a partially written configuration. It also provides registered readback of either array and per-row dirty tracking for the configuration controller.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: bits per word line (row width).
- `NUM_WL`, default 4: number of word lines (rows); ≥ 1, need not be a power of two.
- `ADDR_WIDTH`, default 2: word-line address width; must be ≥ ceil(log2(NUM_WL)), minimum 1.

Ports:
- `clk` in, 1: the one clock; all state updates on its rising edge.
- `reset` in, 1: synchronous, active-high reset.
- `wl_en` in, 1: write enable for the shadow array.
- `wl_addr` in, ADDR_WIDTH: word line to write.
- `bl` in, DATA_WIDTH: bit-line write data.
- `commit` in, 1: copy the whole shadow array into the active array.
- `rd_en` in, 1: readback request.
- `rd_addr` in, ADDR_WIDTH: readback row.
- `rd_sel` in, 1: readback source; 0 = active, 1 = shadow.
- `rd_data` out, DATA_WIDTH: readback data.
- `rd_valid` out, 1: `rd_data` is valid this cycle.
- `Q` out, NUM_WL*DATA_WIDTH: active array, row r at bits [r*DATA_WIDTH +: DATA_WIDTH].
- `Qb` out, NUM_WL*DATA_WIDTH: bitwise inverse of `Q`.
- `dirty` out, NUM_WL: row r of the shadow array was written since the last commit or reset.
- `commit_done` out, 1: one-cycle pulse following an accepted commit.
- `addr_err` out, 1: one-cycle pulse following an out-of-range write or read address.

## Operation
- Reset (`reset`=1 at a rising edge) has priority over everything. It clears shadow, active, `dirty`, `rd_data`, `rd_valid`, `commit_done` and `addr_err` to 0, so after reset `Q`=0 and `Qb`=all ones. Reset mid-operation discards any write, commit or read presented in the same cycle.
- Write: `wl_en`=1 and `wl_addr` < NUM_WL → shadow[`wl_addr`] ← `bl`, `dirty[wl_addr]` ← 1. The active array is unaffected.
- Commit: `commit`=1 → active[r] ← shadow[r] for all r in one edge, `dirty` ← 0, `commit_done`=1 next cycle. Commit is accepted even when no row is dirty.
- Write and commit in the same cycle:
  - The commit copies the shadow contents from before that edge.
  - The write still lands in the shadow array.
  - The written row's `dirty` bit ends at 1; all other `dirty` bits end at 0.
- Readback:
  - `rd_en`=1 with `rd_addr` < NUM_WL → `rd_data` ← selected array[`rd_addr`] as sampled before the edge, and `rd_valid`=1 next cycle.
  - A read and a write to the same shadow row in one cycle returns the old data.
  - When `rd_en`=0, `rd_valid`=0 and `rd_data` holds its last value.
- Out-of-range address (≥ NUM_WL) on an enabled write or read:
  - The write is ignored: no state or `dirty` change.
  - The read gives `rd_valid`=0.
  - `addr_err` pulses for one cycle; a simultaneous in-range operation on the other port still completes.
- No state machine beyond these registers; no operation stalls and there is no backpressure.

## Timing
- Write to shadow: visible to shadow readback on the next edge (read issued 1 cycle later returns the new data).
- Write → `Q` latency: write edge + commit edge; `Q` changes exactly at the commit edge, for all rows at once.
- `Q`/`Qb` are register outputs with no combinational path from any input.
- Readback latency 1 cycle; back-to-back reads every cycle supported.
- `commit_done` and `addr_err` are single-cycle pulses. Consecutive commits give consecutive pulses.

## Test plan
- Reset then idle: `Q`=0, `Qb`=all ones, `dirty`=0, `rd_valid`=0 from the first cycle after reset.
- Write 0xA5 to row 2 → `dirty`=4'b0100 and `Q` unchanged. Commit → next cycle `Q[23:16]`=0xA5, `dirty`=0, `commit_done`=1 for one cycle.
- Write 0x3C to row 1 with commit in the same cycle, shadow row 1 previously 0x11 → `Q[15:8]`=0x11, `dirty`=4'b0010. A second commit gives `Q[15:8]`=0x3C.
- Readback: shadow row 0 = 0x5A, active row 0 = 0x00. `rd_sel`=1 → `rd_data`=0x5A, `rd_valid`=1 one cycle later. `rd_sel`=0 → `rd_data`=0x00.
- NUM_WL=3, ADDR_WIDTH=2: write to address 3 → `addr_err` pulse, shadow and `dirty` unchanged. Read from address 3 → `rd_valid`=0 with `addr_err`=1.
- Assert `reset` in the same cycle as write, commit and read → all state 0, `commit_done`=0, `rd_valid`=0 afterwards.

Source files
------------

// File: rtl/config_latch_bank.sv
// Double-buffered configuration latch bank. Writes go to a shadow array and
// commit copies every shadow row to the active array at once. Includes readback and dirty tracking.
module config_latch_bank #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_WL     = 4,
   parameter int ADDR_WIDTH = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         wl_en,
   input  logic [ADDR_WIDTH-1:0]        wl_addr,
   input  logic [DATA_WIDTH-1:0]        bl,
   input  logic                         commit,
   input  logic                         rd_en,
   input  logic [ADDR_WIDTH-1:0]        rd_addr,
   input  logic                         rd_sel,
   output logic [DATA_WIDTH-1:0]        rd_data,
   output logic                         rd_valid,
   output logic [NUM_WL*DATA_WIDTH-1:0] Q,
   output logic [NUM_WL*DATA_WIDTH-1:0] Qb,
   output logic [NUM_WL-1:0]            dirty,
   output logic                         commit_done,
   output logic                         addr_err
);

   localparam logic [ADDR_WIDTH:0] NUM_WL_A = NUM_WL[ADDR_WIDTH:0];

   logic [NUM_WL-1:0][DATA_WIDTH-1:0] shadow_q, shadow_d;
   logic [NUM_WL-1:0][DATA_WIDTH-1:0] active_q, active_d;
   logic [NUM_WL-1:0]                 dirty_q, dirty_d;
   logic [DATA_WIDTH-1:0]             rd_data_q, rd_data_d;
   logic                              rd_valid_q, rd_valid_d;
   logic                              commit_done_q, commit_done_d;
   logic                              addr_err_q, addr_err_d;

   logic wr_ok, rd_ok;
   logic [DATA_WIDTH-1:0] rd_row;

   assign wr_ok = wl_en && ({1'b0, wl_addr} < NUM_WL_A);
   assign rd_ok = rd_en && ({1'b0, rd_addr} < NUM_WL_A);

   always_comb begin
      shadow_d      = shadow_q;
      // Commit samples the pre-edge shadow, so a same-cycle write lands only in shadow.
      active_d      = commit ? shadow_q : active_q;
      dirty_d       = commit ? '0 : dirty_q;
      rd_row        = '0;
      for (int r = 0; r < NUM_WL; r++) begin
         if (wr_ok && (wl_addr == ADDR_WIDTH'(r))) begin
            shadow_d[r] = bl;
            dirty_d[r]  = 1'b1;
         end
         if (rd_addr == ADDR_WIDTH'(r))
            rd_row = rd_sel ? shadow_q[r] : active_q[r];
      end
      rd_data_d     = rd_ok ? rd_row : rd_data_q;
      rd_valid_d    = rd_ok;
      commit_done_d = commit;
      addr_err_d    = (wl_en && !wr_ok) || (rd_en && !rd_ok);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         shadow_q      <= '0;
         active_q      <= '0;
         dirty_q       <= '0;
         rd_data_q     <= '0;
         rd_valid_q    <= 1'b0;
         commit_done_q <= 1'b0;
         addr_err_q    <= 1'b0;
      end else begin
         shadow_q      <= shadow_d;
         active_q      <= active_d;
         dirty_q       <= dirty_d;
         rd_data_q     <= rd_data_d;
         rd_valid_q    <= rd_valid_d;
         commit_done_q <= commit_done_d;
         addr_err_q    <= addr_err_d;
      end
   end

   // Packed row order already matches the Q layout: row r at [r*DATA_WIDTH +: DATA_WIDTH].
   assign Q           = active_q;
   assign Qb          = ~active_q;
   assign dirty       = dirty_q;
   assign rd_data     = rd_data_q;
   assign rd_valid    = rd_valid_q;
   assign commit_done = commit_done_q;
   assign addr_err    = addr_err_q;

endmodule

// File: tb/tb_config_latch_bank.sv
// Directed bench: a default 4-row bank plus a 3-row bank for out-of-range address cases.
module tb_config_latch_bank;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;

   // 4-row instance
   logic       wl_en, commit, rd_en, rd_sel;
   logic [1:0] wl_addr, rd_addr;
   logic [7:0] bl, rd_data;
   logic       rd_valid, commit_done, addr_err;
   logic [31:0] Q, Qb;
   logic [3:0] dirty;

   // 3-row instance
   logic       n3_wl_en, n3_commit, n3_rd_en, n3_rd_sel;
   logic [1:0] n3_wl_addr, n3_rd_addr;
   logic [7:0] n3_bl, n3_rd_data;
   logic       n3_rd_valid, n3_commit_done, n3_addr_err;
   logic [23:0] n3_Q, n3_Qb;
   logic [2:0] n3_dirty;

   config_latch_bank u_dut (
      .clk(clk), .reset(reset), .wl_en(wl_en), .wl_addr(wl_addr), .bl(bl),
      .commit(commit), .rd_en(rd_en), .rd_addr(rd_addr), .rd_sel(rd_sel),
      .rd_data(rd_data), .rd_valid(rd_valid), .Q(Q), .Qb(Qb), .dirty(dirty),
      .commit_done(commit_done), .addr_err(addr_err)
   );

   config_latch_bank #(.DATA_WIDTH(8), .NUM_WL(3), .ADDR_WIDTH(2)) u_dut3 (
      .clk(clk), .reset(reset), .wl_en(n3_wl_en), .wl_addr(n3_wl_addr), .bl(n3_bl),
      .commit(n3_commit), .rd_en(n3_rd_en), .rd_addr(n3_rd_addr), .rd_sel(n3_rd_sel),
      .rd_data(n3_rd_data), .rd_valid(n3_rd_valid), .Q(n3_Q), .Qb(n3_Qb), .dirty(n3_dirty),
      .commit_done(n3_commit_done), .addr_err(n3_addr_err)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Advance one edge; sample/drive 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wl_en = 0; commit = 0; rd_en = 0; rd_sel = 0; wl_addr = 0; rd_addr = 0; bl = 0;
      n3_wl_en = 0; n3_commit = 0; n3_rd_en = 0; n3_rd_sel = 0;
      n3_wl_addr = 0; n3_rd_addr = 0; n3_bl = 0;
   endtask

   initial begin
      idle();
      reset = 1;
      step();
      reset = 0;
      chk("rst_Q", Q, 32'h0);
      chk("rst_Qb", Qb, 32'hFFFF_FFFF);
      chk("rst_dirty", {28'h0, dirty}, 32'h0);
      chk("rst_rd_valid", {31'h0, rd_valid}, 32'h0);
      chk("rst_commit_done", {31'h0, commit_done}, 32'h0);
      chk("rst_addr_err", {31'h0, addr_err}, 32'h0);
      step();
      chk("idle_Q", Q, 32'h0);

      // write row 2, then commit
      wl_en = 1; wl_addr = 2; bl = 8'hA5;
      step();
      idle();
      chk("wr2_dirty", {28'h0, dirty}, 32'h4);
      chk("wr2_Q_unchanged", Q, 32'h0);
      commit = 1;
      step();
      idle();
      chk("cm1_Q", Q, 32'h00A5_0000);
      chk("cm1_dirty", {28'h0, dirty}, 32'h0);
      chk("cm1_done", {31'h0, commit_done}, 32'h1);
      step();
      chk("cm1_done_pulse", {31'h0, commit_done}, 32'h0);

      // write+commit same cycle copies pre-edge shadow
      wl_en = 1; wl_addr = 1; bl = 8'h11;
      step();
      wl_en = 1; wl_addr = 1; bl = 8'h3C; commit = 1;
      step();
      idle();
      chk("wc_Q", Q, 32'h00A5_1100);
      chk("wc_dirty", {28'h0, dirty}, 32'h2);
      commit = 1;
      step();
      chk("cm2_Q", Q, 32'h00A5_3C00);
      chk("cm2_Qb", Qb, 32'hFF5A_C3FF);
      chk("cm2_dirty", {28'h0, dirty}, 32'h0);
      step();
      idle();
      chk("cm3_back2back_done", {31'h0, commit_done}, 32'h1);

      // readback
      wl_en = 1; wl_addr = 0; bl = 8'h5A;
      step();
      idle();
      rd_en = 1; rd_addr = 0; rd_sel = 1;
      step();
      chk("rd_sh_data", {24'h0, rd_data}, 32'h5A);
      chk("rd_sh_valid", {31'h0, rd_valid}, 32'h1);
      rd_sel = 0;
      step();
      chk("rd_act_data", {24'h0, rd_data}, 32'h00);
      chk("rd_act_valid", {31'h0, rd_valid}, 32'h1);
      rd_sel = 1; wl_en = 1; wl_addr = 0; bl = 8'h77;
      step();
      idle();
      chk("rd_same_row_old", {24'h0, rd_data}, 32'h5A);
      step();
      chk("rd_idle_valid", {31'h0, rd_valid}, 32'h0);
      chk("rd_idle_hold", {24'h0, rd_data}, 32'h5A);
      rd_en = 1; rd_addr = 0; rd_sel = 1;
      step();
      idle();
      chk("rd_new_data", {24'h0, rd_data}, 32'h77);

      // 3-row bank: out-of-range address
      n3_wl_en = 1; n3_wl_addr = 2; n3_bl = 8'h42;
      step();
      idle();
      chk("n3_wr2_dirty", {29'h0, n3_dirty}, 32'h4);
      chk("n3_wr2_err", {31'h0, n3_addr_err}, 32'h0);
      n3_wl_en = 1; n3_wl_addr = 3; n3_bl = 8'hFF;
      step();
      idle();
      chk("n3_wr3_err", {31'h0, n3_addr_err}, 32'h1);
      chk("n3_wr3_dirty", {29'h0, n3_dirty}, 32'h4);
      step();
      chk("n3_err_pulse", {31'h0, n3_addr_err}, 32'h0);
      n3_rd_en = 1; n3_rd_addr = 3; n3_rd_sel = 1;
      step();
      idle();
      chk("n3_rd3_valid", {31'h0, n3_rd_valid}, 32'h0);
      chk("n3_rd3_err", {31'h0, n3_addr_err}, 32'h1);
      n3_wl_en = 1; n3_wl_addr = 3; n3_bl = 8'hEE;
      n3_rd_en = 1; n3_rd_addr = 2; n3_rd_sel = 1;
      step();
      idle();
      chk("n3_mix_valid", {31'h0, n3_rd_valid}, 32'h1);
      chk("n3_mix_data", {24'h0, n3_rd_data}, 32'h42);
      chk("n3_mix_err", {31'h0, n3_addr_err}, 32'h1);
      n3_commit = 1;
      step();
      idle();
      chk("n3_commit_Q", {8'h0, n3_Q}, 32'h0042_0000);

      // reset with write, commit and read all presented
      wl_en = 1; wl_addr = 3; bl = 8'hFF; commit = 1; rd_en = 1; rd_addr = 1; rd_sel = 0;
      reset = 1;
      step();
      reset = 0;
      idle();
      chk("rstop_Q", Q, 32'h0);
      chk("rstop_dirty", {28'h0, dirty}, 32'h0);
      chk("rstop_done", {31'h0, commit_done}, 32'h0);
      chk("rstop_valid", {31'h0, rd_valid}, 32'h0);
      chk("rstop_rd_data", {24'h0, rd_data}, 32'h0);
      chk("rstop_n3_Q", {8'h0, n3_Q}, 32'h0);
      rd_en = 1; rd_addr = 3; rd_sel = 1;
      step();
      idle();
      chk("rstop_shadow3", {24'h0, rd_data}, 32'h0);
      chk("rstop_shadow3_valid", {31'h0, rd_valid}, 32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
